// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM controller.
//   LED_MODE_*     2-bit channel mode encodings (OFF / ON / BLINK / BREATHE)
//   breathe_dir_e  direction of the per-channel breathe ramp
//   chan_width()   width of a channel index; never narrower than one bit
package led_pwm_pkg;

   localparam logic [1:0] LED_MODE_OFF     = 2'd0;
   localparam logic [1:0] LED_MODE_ON      = 2'd1;
   localparam logic [1:0] LED_MODE_BLINK   = 2'd2;
   localparam logic [1:0] LED_MODE_BREATHE = 2'd3;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } breathe_dir_e;

   function automatic int chan_width(input int nr_channels);
      return (nr_channels > 1) ? $clog2(nr_channels) : 1;
   endfunction

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// Configuration write port of the LED PWM controller.
//   cfg_wr     single-cycle write strobe
//   cfg_chan   target channel index (out-of-range indices are ignored by the slave)
//   cfg_mode   LED_MODE_* encoding
//   cfg_level  brightness / breathe peak
// master: CPU PIO or bus bridge side; slave: led_pwm_ctrl.
interface led_pwm_ctrl_if
   import led_pwm_pkg::*;
#(
   parameter int NR_CHANNELS = 3,
   parameter int PWM_BITS    = 8
);
   localparam int CHAN_W = chan_width(NR_CHANNELS);

   logic                cfg_wr;
   logic [CHAN_W-1:0]   cfg_chan;
   logic [1:0]          cfg_mode;
   logic [PWM_BITS-1:0] cfg_level;

   modport master (output cfg_wr, cfg_chan, cfg_mode, cfg_level);
   modport slave  (input  cfg_wr, cfg_chan, cfg_mode, cfg_level);
endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow and active {mode, level}, breathe ramp, duty select,
// PWM compare and the registered pad drive.
//   clk, reset_n   system clock, async active-low reset
//   period_end     last clk of the PWM period; active <= shadow, ramp steps
//   wr_en          decoded config write for this channel
//   cfg_mode/level write data
//   pwm_cnt        shared PWM counter
//   blink_phase    shared blink phase
//   led_out        registered LED drive (polarity set by ACTIVE_LOW)
//
// Breathe direction state:
//   state    | meaning
//   DIR_UP   | ramp climbs by one per period toward level
//   DIR_DOWN | ramp falls by one per period toward 0
module led_pwm_channel
   import led_pwm_pkg::*;
#(
   parameter int PWM_BITS   = 8,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                period_end,
   input  logic                wr_en,
   input  logic [1:0]          cfg_mode,
   input  logic [PWM_BITS-1:0] cfg_level,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                blink_phase,
   output logic                led_out
);
   localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

   logic [1:0]          shadow_mode_q, shadow_mode_d;
   logic [PWM_BITS-1:0] shadow_level_q, shadow_level_d;
   logic [1:0]          active_mode_q, active_mode_d;
   logic [PWM_BITS-1:0] active_level_q, active_level_d;
   logic [PWM_BITS-1:0] ramp_q, ramp_d;
   breathe_dir_e        dir_q, dir_d;
   logic                led_q, led_d;
   logic [PWM_BITS-1:0] duty;
   logic                lit;

   always_comb begin
      shadow_mode_d  = shadow_mode_q;
      shadow_level_d = shadow_level_q;
      active_mode_d  = active_mode_q;
      active_level_d = active_level_q;
      ramp_d         = ramp_q;
      dir_d          = dir_q;

      if (wr_en) begin
         shadow_mode_d  = cfg_mode;
         shadow_level_d = cfg_level;
      end

      if (period_end) begin
         // Active takes the shadow as it was before this edge, so a write
         // landing on period_end waits one more period.
         active_mode_d  = shadow_mode_q;
         active_level_d = shadow_level_q;

         // Ramp steps on the values that were active during the period just
         // ending. Held at 0/up outside BREATHE so entry always starts fresh.
         if (active_mode_q != LED_MODE_BREATHE || active_level_q == '0) begin
            ramp_d = '0;
            dir_d  = DIR_UP;
         end else if (ramp_q > active_level_q) begin
            ramp_d = active_level_q;
            dir_d  = DIR_DOWN;
         end else if (ramp_q == active_level_q || (dir_q == DIR_DOWN && ramp_q != '0)) begin
            ramp_d = ramp_q - ONE;
            dir_d  = (ramp_q == ONE) ? DIR_UP : DIR_DOWN;
         end else begin
            ramp_d = ramp_q + ONE;
            dir_d  = (ramp_q + ONE == active_level_q) ? DIR_DOWN : DIR_UP;
         end
      end
   end

   always_comb begin
      duty = '0;
      case (active_mode_q)
         LED_MODE_ON:      duty = active_level_q;
         LED_MODE_BLINK:   duty = blink_phase ? active_level_q : '0;
         LED_MODE_BREATHE: duty = ramp_q;
         default:          duty = '0;
      endcase
   end

   // Full scale is special-cased so the LED never drops out for one tick.
   assign lit   = (duty == '1) || (pwm_cnt < duty);
   assign led_d = lit ^ ACTIVE_LOW;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_mode_q  <= LED_MODE_OFF;
         shadow_level_q <= '0;
         active_mode_q  <= LED_MODE_OFF;
         active_level_q <= '0;
         ramp_q         <= '0;
         dir_q          <= DIR_UP;
         led_q          <= ACTIVE_LOW;
      end else begin
         shadow_mode_q  <= shadow_mode_d;
         shadow_level_q <= shadow_level_d;
         active_mode_q  <= active_mode_d;
         active_level_q <= active_level_d;
         ramp_q         <= ramp_d;
         dir_q          <= dir_d;
         led_q          <= led_d;
      end
   end

   assign led_out = led_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED PWM driver (off / steady / blink / breathe per channel).
//   clk          system clock (osc25)
//   reset_n      async active-low reset
//   cfg          config write port (led_pwm_ctrl_if.slave)
//   period_end   1-clk pulse on the last clk of each PWM period
//   led_out      registered LED drive, one bit per channel
// Holds the shared timebase (prescaler, PWM counter, blink counter/phase) and
// the channel-index decode; per-channel state lives in led_pwm_channel.
module led_pwm_ctrl
   import led_pwm_pkg::*;
#(
   parameter int NR_CHANNELS = 3,
   parameter int PWM_BITS    = 8,
   parameter int PRESCALE    = 97,
   parameter int BLINK_SHIFT = 8,
   parameter bit ACTIVE_LOW  = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   led_pwm_ctrl_if.slave          cfg,
   output logic                   period_end,
   output logic [NR_CHANNELS-1:0] led_out
);
   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(PRESCALE - 1);

   // Prescaler counts down and ticks on terminal count 0; reloading from
   // PRESCALE-1 out of reset gives the same tick phase as counting up from 0.
   logic [PRE_W-1:0]       pre_cnt_q, pre_cnt_d;
   logic [PWM_BITS-1:0]    pwm_cnt_q, pwm_cnt_d;
   logic [BLINK_SHIFT-1:0] blink_cnt_q, blink_cnt_d;
   logic                   blink_phase_q, blink_phase_d;
   logic                   tick;
   logic                   pe;
   logic [NR_CHANNELS-1:0] wr_en;

   assign tick = (pre_cnt_q == '0);
   assign pe   = tick && (pwm_cnt_q == '1);

   always_comb begin
      pre_cnt_d     = tick ? PRE_RELOAD : pre_cnt_q - PRE_W'(1);
      pwm_cnt_d     = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
      blink_cnt_d   = pe ? blink_cnt_q + BLINK_SHIFT'(1) : blink_cnt_q;
      // Phase flips as the blink counter wraps to 0.
      blink_phase_d = blink_phase_q ^ (pe && (blink_cnt_q == '1));
   end

   always_comb begin
      wr_en = '0;
      for (int i = 0; i < NR_CHANNELS; i++) begin
         wr_en[i] = cfg.cfg_wr && (int'(cfg.cfg_chan) == i);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt_q     <= PRE_RELOAD;
         pwm_cnt_q     <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         pre_cnt_q     <= pre_cnt_d;
         pwm_cnt_q     <= pwm_cnt_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   // Decoded from registers only, so it is clean to export directly.
   assign period_end = pe;

   for (genvar gi = 0; gi < NR_CHANNELS; gi++) begin : g_chan
      led_pwm_channel #(
         .PWM_BITS   (PWM_BITS),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_chan (
         .clk         (clk),
         .reset_n     (reset_n),
         .period_end  (pe),
         .wr_en       (wr_en[gi]),
         .cfg_mode    (cfg.cfg_mode),
         .cfg_level   (cfg.cfg_level),
         .pwm_cnt     (pwm_cnt_q),
         .blink_phase (blink_phase_q),
         .led_out     (led_out[gi])
      );
   end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl: PWM_BITS=4, PRESCALE=2, BLINK_SHIFT=1,
// so one PWM period is 32 clks and a duty d lights the LED for 2*d clks
// (32 clks at full scale).
module tb_led_pwm_ctrl;
   import led_pwm_pkg::*;

   localparam int NR = 3;
   localparam int PB = 4;
   localparam int PS = 2;
   localparam int BS = 1;
   localparam int PERIOD_CLKS = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          period_end;
   logic [NR-1:0] led_out;

   always #5 clk = ~clk;

   led_pwm_ctrl_if #(.NR_CHANNELS(NR), .PWM_BITS(PB)) cfg_if ();

   led_pwm_ctrl #(
      .NR_CHANNELS (NR),
      .PWM_BITS    (PB),
      .PRESCALE    (PS),
      .BLINK_SHIFT (BS),
      .ACTIVE_LOW  (1'b0)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cfg        (cfg_if),
      .period_end (period_end),
      .led_out    (led_out)
   );

   int n_vec = 0;
   int n_err = 0;
   int total_pe;
   int hi [NR];
   int pe_cnt;
   logic [1:0]    pend_chan;
   logic [1:0]    pend_mode;
   logic [PB-1:0] pend_level;
   int exp_ramp [12] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 1, 0};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Leaves the bench one negedge after a period_end negedge.
   task automatic sync_period();
      int k;
      for (k = 0; k < 80; k++) begin
         @(negedge clk);
         if (period_end === 1'b1) break;
      end
      check("sync_period_end_seen", 32'(k < 80), 32'd1);
      if (k < 80) total_pe++;
      @(negedge clk);
   endtask

   // Measures one full period of LED on-time per channel. Entered and left one
   // negedge after a period_end; optionally issues the pending write at step wr_at.
   task automatic run_period(input int wr_at);
      for (int i = 0; i < NR; i++) hi[i] = 0;
      pe_cnt = 0;
      for (int j = 0; j < PERIOD_CLKS; j++) begin
         @(negedge clk);
         for (int i = 0; i < NR; i++) if (led_out[i] === 1'b1) hi[i]++;
         if (period_end === 1'b1) begin
            pe_cnt++;
            total_pe++;
         end
         if (j == wr_at) begin
            cfg_if.cfg_chan  = pend_chan;
            cfg_if.cfg_mode  = pend_mode;
            cfg_if.cfg_level = pend_level;
            cfg_if.cfg_wr    = 1'b1;
         end else begin
            cfg_if.cfg_wr = 1'b0;
         end
      end
   endtask

   task automatic set_pend(input logic [1:0] ch, input logic [1:0] mode, input logic [PB-1:0] lvl);
      pend_chan  = ch;
      pend_mode  = mode;
      pend_level = lvl;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ph;
      reset_n          = 1'b0;
      cfg_if.cfg_wr    = 1'b0;
      cfg_if.cfg_chan  = '0;
      cfg_if.cfg_mode  = LED_MODE_OFF;
      cfg_if.cfg_level = '0;
      total_pe         = 0;
      set_pend(2'd0, LED_MODE_OFF, 4'd0);

      repeat (3) @(negedge clk);
      check("reset_led_out", 32'(led_out), 32'd0);
      check("reset_period_end", 32'(period_end), 32'd0);
      reset_n = 1'b1;

      sync_period();

      // Steady ON, level 4 then 15.
      set_pend(2'd0, LED_MODE_ON, 4'd4);
      run_period(0);
      check("on4_same_period_led0", hi[0], 0);
      check("period_end_once", pe_cnt, 1);
      run_period(-1);
      check("on4_led0", hi[0], 8);
      check("on4_led1_off", hi[1], 0);
      check("on4_led2_off", hi[2], 0);
      set_pend(2'd0, LED_MODE_ON, 4'd15);
      run_period(0);
      check("on15_pending_led0", hi[0], 8);
      run_period(-1);
      check("on15_led0", hi[0], 32);
      check("period_end_once", pe_cnt, 1);

      // Write on the period_end cycle: takes effect one period later.
      set_pend(2'd0, LED_MODE_ON, 4'd2);
      run_period(30);
      check("pe_write_led0_a", hi[0], 32);
      run_period(-1);
      check("pe_write_led0_b", hi[0], 32);
      run_period(-1);
      check("pe_write_led0_c", hi[0], 4);

      // Blink on ch1; write to out-of-range channel 3 must be ignored.
      set_pend(2'd1, LED_MODE_BLINK, 4'd15);
      run_period(0);
      check("blink_pending_led1", hi[1], 0);
      set_pend(2'd3, LED_MODE_ON, 4'd15);
      for (int p = 0; p < 5; p++) begin
         ph = (total_pe >> 1) & 1;
         run_period(p == 0 ? 0 : -1);
         check($sformatf("blink_led1_p%0d", p), hi[1], ph ? 32 : 0);
         check($sformatf("blink_led0_p%0d", p), hi[0], 4);
         check($sformatf("blink_led2_p%0d", p), hi[2], 0);
      end

      // Breathe on ch2, level 3, then lower the peak to 1 while ramping.
      set_pend(2'd2, LED_MODE_BREATHE, 4'd3);
      run_period(0);
      check("breathe_pending_led2", hi[2], 0);
      set_pend(2'd2, LED_MODE_BREATHE, 4'd1);
      for (int p = 0; p < 12; p++) begin
         run_period(p == 8 ? 0 : -1);
         check($sformatf("breathe_led2_p%0d", p), hi[2], 2 * exp_ramp[p]);
      end
      check("period_end_once", pe_cnt, 1);

      // Reset in the middle of breathing.
      @(negedge clk);
      check("pre_reset_led0", 32'(led_out[0]), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async_reset_led_out", 32'(led_out), 32'd0);
      check("async_reset_period_end", 32'(period_end), 32'd0);
      repeat (2) @(negedge clk);
      check("held_reset_led_out", 32'(led_out), 32'd0);
      reset_n  = 1'b1;
      total_pe = 0;
      sync_period();
      run_period(-1);
      check("post_reset_led0", hi[0], 0);
      check("post_reset_led1", hi[1], 0);
      check("post_reset_led2", hi[2], 0);
      check("post_reset_period_end", pe_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
